led_seq_ctrl: RTL and testbench

Sequencing controller for the 8-LED decoder chain. It replaces the free-running down-counter with a commanded sequencer: a requester selects mode and speed over a valid/ready handshake, and the block drives the 3-bit LED index and decoder enable. An internal prescaler produces step ticks from the board clock.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/tick_gen.sv | 34 +++
 rtl/led_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencing controller.
// Mode values match the cmd_mode wire encoding.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_DOWN   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic [2:0] IDX_MAX = 3'd7;

endpackage

// File: rtl/tick_gen.sv
// Step-tick prescaler: one tick every (TICK_DIV >> speed) clocks.
// The counter is cleared on command accept and parked at zero while holding.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       hold,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    // TICK_DIV is a multiple of 8, so every shifted period is exact and fits CW bits.
    assign last = CW'((TICK_DIV >> speed) - 1);
    assign tick = !hold && (cnt == last);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset || clear || hold) begin
            cnt <= '0;
        end else if (cnt == last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Commanded LED sequencer: valid/ready command port selects mode and speed,
// and the FSM steps the registered LED index on prescaler ticks.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [1:0] cmd_speed,
    output logic [2:0] idx,
    output logic       led_en,
    output logic       wrap
);

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    mode_e      new_mode;
    logic [1:0] speed_q, speed_d;
    logic       dir_up_q, dir_up_d;
    logic [2:0] idx_d;
    logic       led_en_d, wrap_d, ready_d;
    logic       accept, tick, holding;

    assign accept   = cmd_valid && cmd_ready;
    assign new_mode = mode_e'(cmd_mode);
    assign holding  = (state_q == ST_HOLD);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .hold  (holding),
        .speed (speed_q),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_DOWN;
            speed_q   <= 2'd0;
            dir_up_q  <= 1'b1;
            idx       <= 3'd0;
            led_en    <= 1'b0;
            wrap      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            dir_up_q  <= dir_up_d;
            idx       <= idx_d;
            led_en    <= led_en_d;
            wrap      <= wrap_d;
            cmd_ready <= ready_d;
        end
    end

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        speed_d  = speed_q;
        dir_up_d = dir_up_q;
        idx_d    = idx;
        led_en_d = led_en;
        wrap_d   = 1'b0;
        ready_d  = !accept;

        if (accept) begin
            // Accept always beats a coincident tick: no step this cycle.
            mode_d   = new_mode;
            speed_d  = cmd_speed;
            led_en_d = 1'b1;
            state_d  = (new_mode == MODE_HOLD) ? ST_HOLD : ST_RUN;
            if (state_q == ST_IDLE) begin
                case (new_mode)
                    MODE_DOWN:   idx_d = IDX_MAX;
                    MODE_UP,
                    MODE_BOUNCE: begin
                        idx_d    = 3'd0;
                        dir_up_d = 1'b1;
                    end
                    default:     idx_d = idx;
                endcase
            end else if (new_mode == MODE_BOUNCE) begin
                dir_up_d = (idx != IDX_MAX);
            end
        end else if (tick && state_q == ST_RUN) begin
            case (mode_q)
                MODE_DOWN: begin
                    idx_d  = idx - 3'd1;
                    wrap_d = (idx == 3'd0);
                end
                MODE_UP: begin
                    idx_d  = idx + 3'd1;
                    wrap_d = (idx == IDX_MAX);
                end
                MODE_BOUNCE: begin
                    if (dir_up_q && idx == IDX_MAX) begin
                        idx_d    = IDX_MAX - 3'd1;
                        dir_up_d = 1'b0;
                        wrap_d   = 1'b1;
                    end else if (!dir_up_q && idx == 3'd0) begin
                        idx_d    = 3'd1;
                        dir_up_d = 1'b1;
                        wrap_d   = 1'b1;
                    end else begin
                        idx_d = dir_up_q ? idx + 3'd1 : idx - 3'd1;
                    end
                end
                default: idx_d = idx;
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios then random
// commands, all compared each cycle against a behavioural reference model.
module tb_led_seq_ctrl;

    localparam int TICK_DIV = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'd0;
    logic [1:0] cmd_speed = 2'd0;
    logic       cmd_ready;
    logic [2:0] idx;
    logic       led_en;
    logic       wrap;

    led_seq_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_speed (cmd_speed),
        .idx       (idx),
        .led_en    (led_en),
        .wrap      (wrap)
    );

    always #5 clock = ~clock;

    // Reference model: state 0 idle, 1 run, 2 hold; elapsed counts cycles since the last accept.
    int m_idx, m_en, m_wrap, m_ready, m_state, m_mode, m_speed, m_up, m_elapsed, m_acc;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int nxt;
        case (m_mode)
            0: begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + 7) % 8;
            end
            1: begin
                m_wrap = (m_idx == 7);
                m_idx  = (m_idx + 1) % 8;
            end
            2: begin
                // Bounce: reflect off the end of the 0..7 range.
                nxt = m_up ? m_idx + 1 : m_idx - 1;
                if (nxt < 0 || nxt > 7) begin
                    m_up   = !m_up;
                    m_wrap = 1;
                    nxt    = m_up ? m_idx + 1 : m_idx - 1;
                end
                m_idx = nxt;
            end
            default: ;
        endcase
    endtask

    task automatic model_edge(input bit v, input int mode, input int spd, input bit rst);
        m_acc = 0;
        if (!rst) begin
            m_idx = 0; m_en = 0; m_wrap = 0; m_ready = 1;
            m_state = 0; m_up = 1; m_elapsed = 0;
        end else if (v && m_ready) begin
            m_acc = 1;
            if (m_state == 0) begin
                if (mode == 0) m_idx = 7;
                else if (mode != 3) begin
                    m_idx = 0;
                    m_up  = 1;
                end
            end else if (mode == 2) begin
                m_up = (m_idx != 7);
            end
            m_mode = mode; m_speed = spd; m_elapsed = 0;
            m_en = 1; m_wrap = 0; m_ready = 0;
            m_state = (mode == 3) ? 2 : 1;
        end else begin
            m_ready = 1;
            m_wrap  = 0;
            m_elapsed++;
            if (m_state == 1 && (m_elapsed % (TICK_DIV >> m_speed)) == 0) model_step();
        end
    endtask

    task automatic cyc(input bit v, input int mode, input int spd, input bit rst = 1'b1);
        @(negedge clock);
        cmd_valid = v;
        cmd_mode  = mode[1:0];
        cmd_speed = spd[1:0];
        reset     = rst;
        @(posedge clock);
        model_edge(v, mode, spd, rst);
        #1;
        check("idx", 32'(idx), m_idx);
        check("led_en", 32'(led_en), m_en);
        check("wrap", 32'(wrap), m_wrap);
        check("cmd_ready", 32'(cmd_ready), m_ready);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0);
    endtask

    // Hold a command until the model accepts it; bounded so a stuck DUT cannot hang the run.
    task automatic send(input int mode, input int spd);
        int tries = 0;
        do begin
            cyc(1'b1, mode, spd);
            tries++;
        end while (!m_acc && tries < 8);
        if (!m_acc) check("send_timeout", 32'(tries), 0);
    endtask

    initial begin
        bit pend;
        int p_mode, p_spd;

        // Reset state.
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        idle(3);

        // DOWN at speed 0: 7,6..0 then wrap to 7.
        send(0, 0);
        idle(70);

        // UP at speed 2, then BOUNCE at speed 3 (accepted from RUN).
        send(1, 2);
        idle(20);
        send(2, 3);
        idle(20);

        // HOLD at idx 3, then resume UP.
        cyc(1'b0, 0, 0, 1'b0);
        send(1, 0);
        idle(24);
        check("pre_hold_idx", 32'(idx), 3);
        send(3, 0);
        idle(50);
        check("hold_idx", 32'(idx), 3);
        check("hold_led_en", 32'(led_en), 1);
        send(1, 0);
        idle(8);

        // Command coincident with tick, then a back-to-back command that must wait.
        send(1, 0);
        idle(7);
        send(2, 1);
        cyc(1'b1, 0, 3);
        check("back_to_back_rejected", 32'(m_acc), 0);
        send(0, 3);
        idle(20);

        // Reset mid-BOUNCE while moving down, then stay static.
        send(2, 3);
        idle(10);
        check("bounce_dir_down_idx", 32'(idx), 4);
        cyc(1'b0, 0, 0, 1'b0);
        idle(10);

        // Random commands, requester holds valid until accepted, occasional reset.
        pend = 0;
        p_mode = 0;
        p_spd = 0;
        repeat (3000) begin
            if (!pend && $urandom_range(0, 15) == 0) begin
                pend   = 1;
                p_mode = $urandom_range(0, 3);
                p_spd  = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 299) == 0) begin
                cyc(pend, p_mode, p_spd, 1'b0);
                pend = 0;
            end else begin
                cyc(pend, p_mode, p_spd);
                if (m_acc) pend = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
